// File: rtl/fifo_uart_tx_if.sv
// FIFO-fed UART transmitter bundle: enable, FIFO head/flag, pop strobe,
// serial line and busy flag. master = FIFO/host side, slave = transmitter.
interface fifo_uart_tx_if #(
  parameter int B = 8
);
  logic         en;
  logic         fifo_empty;
  logic [B-1:0] fifo_data;
  logic         fifo_rd;
  logic         tx;
  logic         busy;

  modport master (
    output en,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx,
    input  busy
  );

  modport slave (
    input  en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx,
    output busy
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO.
// Ports: clk, reset (sync, active-low), bus (slave: en, fifo_empty,
// fifo_data in; fifo_rd, tx, busy out). Frame: start, B data LSB first, SB stop.
module fifo_uart_tx #(
  parameter int B    = 8,
  parameter int DVSR = 16,
  parameter int SB   = 1
) (
  input  logic             clk,
  input  logic             reset,
  fifo_uart_tx_if.slave    bus
);

  localparam int TW   = $clog2(DVSR);
  localparam int NMAX = (B > SB) ? B : SB;
  localparam int BW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(B - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(SB - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] tick;
  logic [BW-1:0] nbit;
  logic [B-1:0]  shreg;
  logic [B-1:0]  shnext;
  logic          tx_q;
  logic          busy_q;
  logic          load;
  logic          tick_end;

  // Pop is gated by reset so the FIFO never loses a word during reset.
  assign load = reset && (state == IDLE)
              && bus.en && !bus.fifo_empty;

  assign tick_end = (tick == TICK_LAST);
  assign shnext   = shreg >> 1;

  assign bus.fifo_rd = load;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      tick   <= '0;
      nbit   <= '0;
      shreg  <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          tick   <= '0;
          nbit   <= '0;
          if (load) begin
            shreg  <= bus.fifo_data;
            state  <= START;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (tick_end) begin
            tick  <= '0;
            tx_q  <= shreg[0];
            state <= DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick_end) begin
            tick  <= '0;
            shreg <= shnext;
            if (nbit == BIT_LAST) begin
              nbit  <= '0;
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              nbit <= nbit + 1'b1;
              tx_q <= shnext[0];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          if (tick_end) begin
            tick <= '0;
            if (nbit == STOP_LAST) begin
              nbit   <= '0;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              nbit <= nbit + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx (B=8, DVSR=4, SB=1).
// FIFO model from a queue, serial decoder on tx, table plus directed sequences.
module tb_fifo_uart_tx;

  localparam int B    = 8;
  localparam int DVSR = 4;
  localparam int SB   = 1;
  localparam int NV   = 5;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_byte;
    logic       exp_stop;
    int         exp_gap;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fifo_uart_tx_if #(.B(B)) bus ();

  fifo_uart_tx #(
    .B(B),
    .DVSR(DVSR),
    .SB(SB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       ovr = 1'b0;
  logic       ovr_empty = 1'b1;
  logic [7:0] ovr_data = 8'h00;

  int   cyc = 0;
  int   rd_cnt;
  int   rd_cyc[$];
  int   busy_cnt;
  int   bad_rd = 0;
  logic rd_s, tx_s, busy_s;
  logic tx_log[$];

  logic [7:0] dec_q[$];
  logic       stop_q[$];
  bit         dec_on = 0;
  int         dec_cnt;
  logic [7:0] dec_sh;

  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear();
    rd_cnt = 0;
    busy_cnt = 0;
    rd_cyc.delete();
    tx_log.delete();
    dec_q.delete();
    stop_q.delete();
  endtask

  // One clock: drive FIFO view, observe outputs, decode, advance edge.
  task automatic cycle();
    if (ovr) begin
      bus.fifo_empty = ovr_empty;
      bus.fifo_data  = ovr_data;
    end else begin
      bus.fifo_empty = (q.size() == 0);
      bus.fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    end
    #1;
    rd_s   = bus.fifo_rd;
    tx_s   = bus.tx;
    busy_s = bus.busy;
    tx_log.push_back(tx_s);
    if (busy_s === 1'b1) busy_cnt++;
    if (rd_s === 1'b1) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      if (bus.fifo_empty || busy_s || !reset || !bus.en) bad_rd++;
    end
    if (!reset) begin
      dec_on = 0;
    end else if (!dec_on) begin
      if (tx_s === 1'b0) begin
        dec_on  = 1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= 6 && dec_cnt <= 34 && dec_cnt % 4 == 2)
        dec_sh = {tx_s, dec_sh[7:1]};
      if (dec_cnt == 38) begin
        dec_q.push_back(dec_sh);
        stop_q.push_back(tx_s);
      end
      if (dec_cnt == 39) dec_on = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s === 1'b1 && !ovr && q.size() != 0) void'(q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_rd(input string name, input int max);
    int start;
    int n;
    start = rd_cnt;
    n = 0;
    while (rd_cnt == start && n < max) begin
      cycle();
      n++;
    end
    chk(name, rd_cnt - start, 1);
  endtask

  task automatic run_until_frames(input int nf, input int max);
    int n;
    n = 0;
    while (dec_q.size() < nf && n < max) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    int base;
    int mism;
    int zeros;

    vt[0] = '{8'hA3, 8'hA3, 1'b1, 0};
    vt[1] = '{8'h00, 8'h00, 1'b1, 41};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 41};
    vt[3] = '{8'h81, 8'h81, 1'b1, 41};
    vt[4] = '{8'h3C, 8'h3C, 1'b1, 41};

    bus.en = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_data = 8'h00;
    @(posedge clk);
    #1;

    // Reset for 2 cycles, then idle with empty FIFO.
    clear();
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    clear();
    cycle();
    chk("reset tx", tx_s, 1);
    chk("reset busy", busy_s, 0);
    chk("reset rd", rd_s, 0);
    run(99);
    zeros = 0;
    foreach (tx_log[i]) if (tx_log[i] !== 1'b1) zeros++;
    chk("idle tx low cycles", zeros, 0);
    chk("idle busy cycles", busy_cnt, 0);
    chk("idle rd pulses", rd_cnt, 0);

    // Single 0x55 frame, cycle-exact waveform.
    clear();
    q.push_back(8'h55);
    run_until_rd("0x55 pop", 10);
    base = tx_log.size() - 1;
    run(44);
    mism = 0;
    for (int i = 1; i <= 44; i++) begin
      logic e;
      e = (i <= 40) ? logic'(((i - 1) / 4) % 2) : 1'b1;
      if (tx_log[base + i] !== e) mism++;
    end
    chk("0x55 waveform mismatches", mism, 0);
    chk("0x55 busy cycles", busy_cnt, 40);
    chk("0x55 rd pulses", rd_cnt, 1);
    chk("0x55 frames", dec_q.size(), 1);
    if (dec_q.size() >= 1) chk("0x55 byte", dec_q[0], 8'h55);

    // Table: back-to-back words.
    clear();
    for (int i = 0; i < NV; i++) q.push_back(vt[i].word);
    run_until_frames(NV, NV * 45 + 10);
    chk("table frames", dec_q.size(), NV);
    chk("table rd pulses", rd_cyc.size(), NV);
    for (int i = 0; i < NV; i++) begin
      if (i < dec_q.size()) begin
        chk($sformatf("table byte %0d", i), dec_q[i], vt[i].exp_byte);
        chk($sformatf("table stop %0d", i), stop_q[i], vt[i].exp_stop);
      end
      if (i > 0 && i < rd_cyc.size())
        chk($sformatf("table gap %0d", i),
            rd_cyc[i] - rd_cyc[i-1], vt[i].exp_gap);
    end
    run(5);

    // en low blocks pops; first pop in the cycle en is sampled high.
    clear();
    bus.en = 1'b0;
    q.push_back(8'h96);
    run(20);
    chk("en0 rd pulses", rd_cnt, 0);
    chk("en0 busy cycles", busy_cnt, 0);
    bus.en = 1'b1;
    cycle();
    chk("en1 immediate rd", rd_s, 1);
    run(44);
    chk("en1 frames", dec_q.size(), 1);
    if (dec_q.size() >= 1) chk("en1 byte", dec_q[0], 8'h96);

    // Reset mid-frame discards 0x0F; 0x3C follows intact.
    clear();
    q.push_back(8'h0F);
    q.push_back(8'h3C);
    run_until_rd("rst frame pop", 10);
    run(15);
    reset = 1'b0;
    cycle();
    chk("rst cycle rd", rd_s, 0);
    reset = 1'b1;
    cycle();
    chk("post rst tx", tx_s, 1);
    chk("post rst busy", busy_s, 0);
    run_until_frames(1, 60);
    run(3);
    chk("rst frames", dec_q.size(), 1);
    if (dec_q.size() >= 1) chk("rst next byte", dec_q[0], 8'h3C);
    chk("rst fifo drained", q.size(), 0);

    // FIFO inputs change mid-frame.
    clear();
    q.push_back(8'hC5);
    run_until_rd("chg pop", 10);
    run(10);
    ovr = 1'b1;
    ovr_data = 8'h3A;
    ovr_empty = 1'b1;
    run(8);
    ovr_empty = 1'b0;
    run(2);
    ovr_empty = 1'b1;
    run(30);
    chk("chg frames", dec_q.size(), 1);
    if (dec_q.size() >= 1) chk("chg byte", dec_q[0], 8'hC5);
    chk("chg rd pulses", rd_cnt, 1);
    ovr = 1'b0;

    // en falls mid-frame: frame completes, then hold.
    clear();
    q.push_back(8'h12);
    q.push_back(8'h34);
    run_until_rd("enfall pop", 10);
    run(10);
    bus.en = 1'b0;
    run(60);
    chk("enfall frames", dec_q.size(), 1);
    if (dec_q.size() >= 1) chk("enfall byte", dec_q[0], 8'h12);
    chk("enfall rd pulses", rd_cnt, 1);
    chk("enfall busy cycles", busy_cnt, 40);
    chk("enfall queue left", q.size(), 1);
    bus.en = 1'b1;
    run(45);
    chk("enfall resume frames", dec_q.size(), 2);
    if (dec_q.size() >= 2) chk("enfall resume byte", dec_q[1], 8'h34);

    chk("illegal rd pulses", bad_rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter B, default 8, meaning data bits per frame and FIFO word width.
REQ-002 The block SHALL have parameter DVSR, default 16, meaning clk cycles per serial bit; legal range 2..65535.
REQ-003 The block SHALL have parameter SB, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: permits starting a new frame; a frame in progress is never aborted by en.
REQ-007 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-008 The block SHALL have port fifo_data, input, B bits: upstream FIFO head word, valid while fifo_empty=0 (first-word-fall-through).
REQ-009 The block SHALL have port fifo_rd, output, 1 bit: one-cycle pop strobe to the FIFO.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA and STOP; all outputs SHALL be registered except fifo_rd, which is decoded combinationally in IDLE.
REQ-013 In IDLE with en=1 and fifo_empty=0, the block SHALL assert fifo_rd for that cycle, load fifo_data into a B-bit shift register and enter START on the next edge.
REQ-014 In IDLE with en=0 or fifo_empty=1, fifo_rd SHALL be 0 and the state SHALL remain IDLE.
REQ-015 fifo_rd SHALL never be asserted outside IDLE, and SHALL never be asserted while fifo_empty=1.
REQ-016 In START, tx SHALL be 0 for exactly DVSR cycles.
REQ-017 In DATA, the block SHALL send B bits LSB first, each held for exactly DVSR cycles; the shift register shifts right at each bit boundary.
REQ-018 In STOP, tx SHALL be 1 for exactly SB*DVSR cycles, after which the state SHALL return to IDLE.
REQ-019 In IDLE, tx SHALL be 1.
REQ-020 A single tick counter SHALL count 0..DVSR-1 and clear at each bit boundary; a bit counter SHALL count data bits 0..B-1 and stop bits 0..SB-1.
REQ-021 Both counters SHALL be sized by $clog2 of their maximum value and SHALL never wrap inside a bit.
REQ-022 One frame SHALL occupy 1+B+SB bit periods; the back-to-back frame period SHALL be DVSR*(1+B+SB)+1 cycles, because the single IDLE load cycle is included.
REQ-023 fifo_data changes or fifo_empty toggles during START, DATA or STOP SHALL NOT affect the frame in progress.
REQ-024 If en falls mid-frame, the current frame SHALL complete, and the block SHALL then hold in IDLE.

Reset
REQ-025 When reset=0 at a rising clk edge, the next state SHALL be IDLE with tx=1, busy=0, fifo_rd=0, all counters=0 and the shift register=0.
REQ-026 reset SHALL take priority over every other input; a frame interrupted by reset SHALL be discarded and not retransmitted.
REQ-027 fifo_rd SHALL be 0 during any cycle in which reset=0.

Verification (B=8, DVSR=4, SB=1)
REQ-028 Apply reset for 2 cycles, then release with fifo_empty=1 and en=1 -> tx=1, busy=0 and fifo_rd=0 for 100 cycles.
REQ-029 Present fifo_data=0x55 with fifo_empty=0 for one IDLE cycle -> fifo_rd=1 for exactly 1 cycle; tx then follows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, and busy is high for 40 cycles.
REQ-030 Feed 3 words 0xA3, 0x00, 0xFF back-to-back -> 3 fifo_rd pulses spaced 41 cycles apart; decoded bytes are 0xA3, 0x00, 0xFF; each stop bit is 1.
REQ-031 Hold en=0 with fifo_empty=0, then raise en -> no fifo_rd while en=0; the first fifo_rd occurs in the cycle en=1 is sampled.
REQ-032 Assert reset for 1 cycle at cycle 15 of a 0x0F frame -> next cycle tx=1, busy=0 and fifo_rd=0; the next queued word is sent complete and in order.
REQ-033 Change fifo_data and set fifo_empty=1 mid-frame -> the serial output still equals the latched byte, and the following IDLE shows no fifo_rd.
